// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cpu_pkg                                                    |
// | Purpose  : Shared CPU datapath constants and types. Holds the default  |
// |            PC width, the reset PC, the return-address-stack depth and  |
// |            the pc_t program-counter type.                              |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package cpu_pkg;

   localparam int PC_W      = 16;
   localparam int RAS_DEPTH = 4;

   typedef logic [PC_W-1:0] pc_t;

   localparam pc_t RESET_PC = 16'h0000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : ras_stack                                                  |
// | Purpose  : Circular return-address stack. A push onto a full stack    |
// |            overwrites the oldest entry; overflow and underflow set a   |
// |            sticky error flag that only reset clears.                   |
// | Ports    : clk, rst_n (async, active-low)                              |
// |            push_i, pop_i  - one operation per edge (already enabled)   |
// |            wdata_i        - address pushed                             |
// |            top_o          - top entry, 0 when empty                    |
// |            empty_o/full_o - occupancy flags                            |
// |            err_o          - sticky overflow/underflow                  |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module ras_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         err_o
);

   localparam int                 PTR_W   = $clog2(DEPTH);
   localparam int                 CNT_W   = PTR_W + 1;
   localparam logic [PTR_W-1:0]   C_PTR_1 = PTR_W'(1);
   localparam logic [CNT_W-1:0]   C_CNT_1 = CNT_W'(1);
   localparam logic [CNT_W-1:0]   C_FULL  = CNT_W'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;   // index of the current top entry
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic             is_empty, is_full;

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == C_FULL);

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (push_i && pop_i && !is_empty) begin
         // Coroutine swap: replace the top in place, depth unchanged.
         wr_en  = 1'b1;
         wr_idx = ptr_q;
      end else if (push_i) begin
         // Advancing the pointer onto the oldest slot when full gives the
         // circular overwrite for free.
         wr_en  = 1'b1;
         wr_idx = ptr_q + C_PTR_1;
         ptr_d  = ptr_q + C_PTR_1;
         if (is_full) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + C_CNT_1;
         end
         // push+pop on an empty stack is an underflow that still pushes.
         if (pop_i) begin
            err_d = 1'b1;
         end
      end else if (pop_i) begin
         if (is_empty) begin
            err_d = 1'b1;
         end else begin
            ptr_d = ptr_q - C_PTR_1;
            cnt_d = cnt_q - C_CNT_1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Storage needs no reset: its contents are masked while the count is 0.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wdata_i;
      end
   end

   assign top_o   = is_empty ? '0 : mem_q[ptr_q];
   assign empty_o = is_empty;
   assign full_o  = is_full;
   assign err_o   = err_q;

endmodule : ras_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pc_unit                                                    |
// | Purpose  : Program-counter register with incrementer and optional     |
// |            return-address stack for call/return.                       |
// | Ports    : clk, rst_n (async, active-low)                              |
// |            next_pc   - selected next PC from the upstream mux          |
// |            en        - advance enable (stall when 0)                   |
// |            call/ret  - push return address / pop and jump              |
// |            pc        - current PC (registered)                         |
// |            pc_plus1  - pc + 1, wrapping                                |
// |            ret_addr, ras_empty, ras_full, ras_err - RAS status         |
// | Config   : PC_RAS_EN defined -> RAS compiled in; undefined -> call/ret |
// |            ignored, RAS outputs tied to their empty-stack values.      |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module pc_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W      = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter int              RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] next_pc,
   input  logic            en,
   input  logic            call,
   input  logic            ret,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   output logic [PC_W-1:0] ret_addr,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_err
);

   localparam logic [PC_W-1:0] C_ONE = PC_W'(1);

   logic [PC_W-1:0] pc_q, pc_d;

   assign pc_plus1 = pc_q + C_ONE;
   assign pc       = pc_q;

`ifdef PC_RAS_EN
   logic ras_push, ras_pop;

   assign ras_push = en & call;
   assign ras_pop  = en & ret;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .wdata_i (pc_plus1),
      .top_o   (ret_addr),
      .empty_o (ras_empty),
      .full_o  (ras_full),
      .err_o   (ras_err)
   );

   // A return on a non-empty stack takes the old top (also covers the swap);
   // an underflowing return falls through to next_pc.
   always_comb begin
      pc_d = pc_q;
      if (en) begin
         if (ret && !ras_empty) begin
            pc_d = ret_addr;
         end else begin
            pc_d = next_pc;
         end
      end
   end
`else
   logic unused_ctl;

   assign unused_ctl = call | ret;
   assign ret_addr   = '0;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign ras_err    = 1'b0;

   always_comb begin
      pc_d = pc_q;
      if (en) begin
         pc_d = next_pc;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_pc_unit                                                 |
// | Purpose  : Directed self-checking bench for pc_unit. Expectations for  |
// |            the RAS follow the PC_RAS_EN build setting.                 |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] next_pc;
   logic        en, call, ret;
   logic [15:0] pc, pc_plus1, ret_addr;
   logic        ras_empty, ras_full, ras_err;

   int checks   = 0;
   int failures = 0;

   pc_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_pc   (next_pc),
      .en        (en),
      .call      (call),
      .ret       (ret),
      .pc        (pc),
      .pc_plus1  (pc_plus1),
      .ret_addr  (ret_addr),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_err   (ras_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, return at the following falling edge.
   task automatic step(input logic e, input logic c, input logic r, input logic [15:0] n);
      en = e; call = c; ret = r; next_pc = n;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0; call = 1'b0; ret = 1'b0; next_pc = 16'h0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; call = 1'b0; ret = 1'b0; next_pc = 16'h0;
      #1;
      chk("rst_pc",       pc,                16'h0000);
      chk("rst_pc_plus1", pc_plus1,          16'h0001);
      chk("rst_ret_addr", ret_addr,          16'h0000);
      chk("rst_empty",    {15'b0, ras_empty}, 16'h1);
      chk("rst_full",     {15'b0, ras_full},  16'h0);
      chk("rst_err",      {15'b0, ras_err},   16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential stepping
      step(1, 0, 0, pc_plus1); chk("seq_pc1", pc, 16'h0001);
      step(1, 0, 0, pc_plus1); chk("seq_pc2", pc, 16'h0002);
      step(1, 0, 0, pc_plus1); chk("seq_pc3", pc, 16'h0003);
      chk("seq_empty", {15'b0, ras_empty}, 16'h1);

      // Stall holds everything, call ignored
      step(0, 1, 0, 16'h1234);
      chk("stall_pc",    pc,                 16'h0003);
      chk("stall_empty", {15'b0, ras_empty}, 16'h1);

      // Wrap
      step(1, 0, 0, 16'hFFFF);
      chk("wrap_pc",     pc,       16'hFFFF);
      chk("wrap_plus1",  pc_plus1, 16'h0000);
      step(1, 0, 0, pc_plus1);
      chk("wrap_pc0",    pc,                16'h0000);
      chk("wrap_err",    {15'b0, ras_err},  16'h0);

      step(1, 0, 0, 16'h0010);
      chk("jmp_plus1", pc_plus1, 16'h0011);

`ifdef PC_RAS_EN
      // Call / return
      step(1, 1, 0, 16'h0100);
      chk("call_pc",   pc,                 16'h0100);
      chk("call_top",  ret_addr,           16'h0011);
      chk("call_empty",{15'b0, ras_empty}, 16'h0);
      step(1, 0, 0, 16'h0101);
      chk("body_pc",   pc,                 16'h0101);
      step(1, 0, 1, 16'h0555);
      chk("ret_pc",    pc,                 16'h0011);
      chk("ret_empty", {15'b0, ras_empty}, 16'h1);

      // Overflow: five calls, depth four
      step(1, 1, 0, 16'h1000); chk("ovf_full1", {15'b0, ras_full}, 16'h0);
      step(1, 1, 0, 16'h2000); chk("ovf_full2", {15'b0, ras_full}, 16'h0);
      step(1, 1, 0, 16'h3000); chk("ovf_full3", {15'b0, ras_full}, 16'h0);
      step(1, 1, 0, 16'h4000);
      chk("ovf_full4", {15'b0, ras_full}, 16'h1);
      chk("ovf_err4",  {15'b0, ras_err},  16'h0);
      step(1, 1, 0, 16'h5000);
      chk("ovf_full5", {15'b0, ras_full}, 16'h1);
      chk("ovf_err5",  {15'b0, ras_err},  16'h1);
      chk("ovf_pc5",   pc,                16'h5000);
      step(1, 0, 1, 16'h0999); chk("pop1", pc, 16'h4001);
      step(1, 0, 1, 16'h0999); chk("pop2", pc, 16'h3001);
      step(1, 0, 1, 16'h0999); chk("pop3", pc, 16'h2001);
      step(1, 0, 1, 16'h0999); chk("pop4", pc, 16'h1001);
      chk("pop_empty",  {15'b0, ras_empty}, 16'h1);
      chk("pop_err",    {15'b0, ras_err},   16'h1);

      // Underflow
      do_reset();
      chk("ufl_rst_err", {15'b0, ras_err}, 16'h0);
      step(1, 0, 1, 16'h0200);
      chk("ufl_pc",    pc,                16'h0200);
      chk("ufl_err",   {15'b0, ras_err},  16'h1);
      step(0, 1, 0, 16'h0abc);
      chk("ufl_hold_pc",    pc,                 16'h0200);
      chk("ufl_hold_empty", {15'b0, ras_empty}, 16'h1);

      // Coroutine swap
      do_reset();
      step(1, 0, 0, 16'h0020);
      step(1, 1, 0, 16'h0300);
      chk("swp_top0", ret_addr, 16'h0021);
      step(1, 1, 1, 16'h0777);
      chk("swp_pc",   pc,                 16'h0021);
      chk("swp_top",  ret_addr,           16'h0301);
      chk("swp_err",  {15'b0, ras_err},   16'h0);
      step(1, 0, 1, 16'h0777);
      chk("swp_ret",  pc,                 16'h0301);
      chk("swp_empty",{15'b0, ras_empty}, 16'h1);

      // Empty call+ret: pushes, jumps to next_pc, flags error
      step(1, 1, 1, 16'h0400);
      chk("ecr_pc",  pc,               16'h0400);
      chk("ecr_top", ret_addr,         16'h0302);
      chk("ecr_err", {15'b0, ras_err}, 16'h1);

      // Async reset with two entries
      do_reset();
      step(1, 1, 0, 16'h0040);
      step(1, 1, 0, 16'h0050);
      chk("ar_pre_top", ret_addr, 16'h0041);
`else
      // RAS compiled out: call/ret are plain jumps
      step(1, 1, 0, 16'h0100);
      chk("nr_call_pc",  pc,                 16'h0100);
      chk("nr_call_top", ret_addr,           16'h0000);
      chk("nr_empty",    {15'b0, ras_empty}, 16'h1);
      step(1, 0, 1, 16'h0200);
      chk("nr_ret_pc",   pc,                 16'h0200);
      chk("nr_err",      {15'b0, ras_err},   16'h0);
      step(1, 1, 1, 16'h0300);
      chk("nr_cr_pc",    pc,                 16'h0300);
      chk("nr_full",     {15'b0, ras_full},  16'h0);
`endif

      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_pc",    pc,                 16'h0000);
      chk("ar_plus1", pc_plus1,           16'h0001);
      chk("ar_top",   ret_addr,           16'h0000);
      chk("ar_empty", {15'b0, ras_empty}, 16'h1);
      chk("ar_full",  {15'b0, ras_full},  16'h0);
      chk("ar_err",   {15'b0, ras_err},   16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 16'h0077);
      chk("post_ar_pc", pc, 16'h0077);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pc_unit
`default_nettype wire
